// File: rtl/steer_quad_gen.sv
// rtl/steer_quad_gen.sv - joystick left/right to Gray-coded quadrature steering, with step-rate acceleration
module steer_quad_gen #(
   parameter int CHANNELS    = 2,
   parameter int DIV_W       = 16,
   parameter int ACCEL_SHIFT = 3
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [DIV_W-1:0]      clkdiv,
   input  logic [DIV_W-1:0]      clkdiv_min,
   input  logic [CHANNELS-1:0]   left,
   input  logic [CHANNELS-1:0]   right,
   output logic [2*CHANNELS-1:0] steer,
   output logic [CHANNELS-1:0]   moving
);

   typedef enum logic [1:0] {
      DIR_IDLE = 2'd0,
      DIR_R    = 2'd1,
      DIR_L    = 2'd2
   } dir_t;

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [CHANNELS-1:0] r_l1, r_l2, r_r1, r_r2;
   logic [DIV_W-1:0]    w_base, w_floor_raw, w_floor;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_l1 <= '0;
         r_l2 <= '0;
         r_r1 <= '0;
         r_r2 <= '0;
      end else begin
         r_l1 <= left;
         r_l2 <= r_l1;
         r_r1 <= right;
         r_r2 <= r_r1;
      end
   end

   // A zero base period means "every cycle"; the floor never exceeds the base and never drops below 1.
   always_comb begin
      w_base      = (clkdiv == '0) ? ONE : clkdiv;
      w_floor_raw = (clkdiv_min < w_base) ? clkdiv_min : w_base;
      w_floor     = (w_floor_raw == '0) ? ONE : w_floor_raw;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [1:0]       r_q;
      logic [DIV_W-1:0] r_t;
      logic [DIV_W-1:0] r_p;
      dir_t             r_d;
      logic [1:0]       r_steer;
      logic             r_moving;

      dir_t             w_dir;
      logic [1:0]       w_qstep;
      logic [DIV_W-1:0] w_pdec;
      logic [DIV_W-1:0] w_pn;

      always_comb begin
         w_dir = DIR_IDLE;
         if (r_r2[i] && !r_l2[i]) begin
            w_dir = DIR_R;
         end else if (r_l2[i] && !r_r2[i]) begin
            w_dir = DIR_L;
         end
         // Gray walk: R is 00->01->11->10, L is the reverse.
         w_qstep = (w_dir == DIR_L) ? {~r_q[0], r_q[1]} : {r_q[0], ~r_q[1]};
         w_pdec  = r_p - (r_p >> ACCEL_SHIFT);
         if (ACCEL_SHIFT == 0) begin
            w_pn = r_p;
         end else begin
            w_pn = (w_pdec < w_floor) ? w_floor : w_pdec;
         end
      end

      always_ff @(posedge CLK or posedge reset) begin
         if (reset) begin
            r_q      <= 2'b00;
            r_t      <= '0;
            r_p      <= '0;
            r_d      <= DIR_IDLE;
            r_steer  <= 2'b00;
            r_moving <= 1'b0;
         end else begin
            if (w_dir == DIR_IDLE) begin
               r_t <= '0;
               r_p <= w_base;
            end else if (w_dir != r_d) begin
               r_q <= w_qstep;
               r_p <= w_base;
               r_t <= w_base - ONE;
            end else if (r_t == '0) begin
               r_q <= w_qstep;
               r_p <= w_pn;
               r_t <= w_pn - ONE;
            end else begin
               r_t <= r_t - ONE;
            end
            r_d     <= w_dir;
            r_steer <= r_q;
            // Taken from r_d so moving rises on the same edge as the first visible step.
            r_moving <= (r_d != DIR_IDLE);
         end
      end

      assign steer[2*i+1 -: 2] = r_steer;
      assign moving[i]         = r_moving;
   end

endmodule

// File: doc/steer_quad_gen.md
# steer_quad_gen

Multi-channel digital-joystick-to-quadrature steering encoder with acceleration. It replaces the fixed-rate per-player joystick-to-quadrature converters. Each channel turns a left/right button pair into a 2-bit Gray-coded quadrature pair (A,B) for the game core's steering inputs. Step rate ramps from a base period toward a minimum period while a direction is held. One instance serves all players and sits between the joystick mapping in `emu` and the core's `Steer_xA_I`/`Steer_xB_I` inputs.

## Interface
Parameters:
- CHANNELS, 2, number of independent steering channels (1..8).
- DIV_W, 16, width of the period, timer and divider registers.
- ACCEL_SHIFT, 3, acceleration strength; 0 disables acceleration (constant period).

Ports:
- CLK  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clkdiv  in  DIV_W  base step period in CLK cycles, shared by all channels; a value of 0 is treated as 1.
- clkdiv_min  in  DIV_W  minimum step period (acceleration floor). If clkdiv_min > clkdiv, the floor is clkdiv, so there is no ramp.
- left  in  CHANNELS  per-channel left request, active-high, asynchronous to CLK.
- right  in  CHANNELS  per-channel right request, active-high, asynchronous to CLK.
- steer  out  2*CHANNELS  per-channel quadrature output; steer[2i+1]=A, steer[2i]=B for channel i.
- moving  out  CHANNELS  high while channel i has an active direction (post-synchroniser).

## Operation
- Synchroniser: left and right pass through a 2-flop synchroniser per bit. All logic below uses the synchronised values.
- Direction: dir = R if right&~left; L if left&~right; IDLE otherwise (both pressed counts as IDLE).
- Per-channel registers:
  - Q: 2-bit phase.
  - T: timer, DIV_W bits.
  - P: current period, DIV_W bits.
  - D: direction of the previous cycle.
- Quadrature sequence:
  - R advances Q as 00→01→11→10→00.
  - L moves Q the opposite way: 00→10→11→01→00.
  - steer = Q, registered.
- Per cycle, for each channel, in priority order:
  1. dir == IDLE: T←0, P←clkdiv, Q holds.
  2. dir ≠ D (new press or reversal): immediate step of Q in dir; P←clkdiv; T←clkdiv−1.
  3. T == 0: step Q in dir; P←Pn; T←Pn−1.
  4. Otherwise T←T−1.
  - Then D←dir.
- Pn = max(P − (P >> ACCEL_SHIFT), floor), where floor = min(clkdiv_min, clkdiv) and floor ≥ 1. If ACCEL_SHIFT = 0, Pn = P.
- Arithmetic: unsigned, DIV_W bits. P − (P>>S) cannot underflow. The clamp is applied after subtraction.
- Changes to clkdiv while a direction is held take effect only at the next P reload (IDLE or new press).
- Channels are fully independent and share only clkdiv and clkdiv_min.
- moving[i] = (dir_i ≠ IDLE), registered.

## Timing
- Reset (async assert, release synchronous to CLK): synchroniser flops 0, Q=00, T=0, P=0, D=IDLE, steer=0, moving=0.
- Latency: an input edge sampled at CLK edge k produces the first step on steer and moving=1 at edge k+3 (2 synchroniser stages plus 1 output register).
- After the first step, successive steps on a held direction are spaced P cycles apart. The first interval equals clkdiv.
- Release: steer freezes at its current phase on the cycle release reaches dir. There are no further steps.
- Reversal without passing through IDLE: the step in the new direction happens on the cycle after the change, and the period resets to clkdiv.
- Exactly one phase transition per step. A and B never change in the same cycle.
- Reset mid-step: outputs return to 00 immediately (asynchronous). The first step after release needs a fresh press, or a held direction, seen against D=IDLE.

## Test plan
- Reset: assert reset with right held → steer=0 and moving=0 while reset is asserted. After release, the first step (01 on channel 0) appears 3 cycles after the first clock edge.
- Constant rate: ACCEL_SHIFT=0, clkdiv=4, hold right[0] → steer[1:0] goes 01,11,10,00,01, steps exactly 4 cycles apart.
- Acceleration: ACCEL_SHIFT=2, clkdiv=16, clkdiv_min=8, hold left[0] → phases 10,11,01,00,… with intervals 16,12,9,8,8,8.
- Reversal and both pressed:
  - Hold right for 3 steps, then switch to left → Q steps back one phase the cycle after the change, and the next interval is clkdiv.
  - Press both buttons → Q holds and moving=0.
- Independence: CHANNELS=2, channel 0 right and channel 1 left at the same time with different press times → each pair follows its own sequence. Releasing channel 1 leaves channel 0's timing unaffected.
- Edge values:
  - clkdiv=0 → one step every cycle.
  - clkdiv_min=20 with clkdiv=10 → intervals fixed at 10.
  - Assert reset mid-hold → steer=0 asynchronously.
